skinny_subcells_serial: RTL

Nibble-serial SubCells controller for the 3-share SKINNY-64 datapath. It latches a 64-bit state held as three Boolean shares and issues one nibble per cycle to a single 3-share SKINNY S-box instance. The S-box is external and has a registered compression layer, so its latency is 1 cycle. The block drives the S-box's 72-bit fresh randomness and its 8-bit neighbouring-share input, then reassembles the 3-share S-box outputs into a 64-bit 3-share result. It sits between the round-state register and the S-box, and it also consumes the S-box output.

---
 rtl/skinny_subcells_serial.sv | 130 +++++++++++++
 1 files changed

// File: rtl/skinny_subcells_serial.sv
// Nibble-serial SubCells sequencer for the 3-share SKINNY-64 state: feeds one
// nibble per randomness word to an external masked S-box and reassembles its outputs.
//
// state | meaning
// IDLE  | waiting for start, result shares held
// FEED  | issuing nibbles, one per cycle with rnd_valid
// DRAIN | all nibbles issued, collecting the S-box pipeline tail
// DONE  | one-cycle done pulse, result complete
module skinny_subcells_serial #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in_share1,
  input  logic [4*NIBBLES-1:0] in_share2,
  input  logic [4*NIBBLES-1:0] in_share3,
  input  logic [71:0]          rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [3:0]           sbox_in1,
  output logic [3:0]           sbox_in2,
  output logic [3:0]           sbox_in3,
  output logic [7:0]           sbox_nb,
  output logic [71:0]          sbox_r,
  input  logic [3:0]           sbox_out1,
  input  logic [3:0]           sbox_out2,
  input  logic [3:0]           sbox_out3,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] out_share1,
  output logic [4*NIBBLES-1:0] out_share2,
  output logic [4*NIBBLES-1:0] out_share3
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [W-1:0]        st1, st2, st3;
  logic [IW-1:0]       idx, nb_idx;
  logic [CW-1:0]       wr_idx;
  logic [SBOX_LAT-1:0] vld, vld_nxt;
  logic                issue, last_issue, capture, last_capture;

  assign issue        = (state == FEED) && rnd_valid;
  assign last_issue   = issue && (idx == IW'(NIBBLES - 1));
  assign capture      = vld[SBOX_LAT-1] && ((state == FEED) || (state == DRAIN));
  assign last_capture = capture && (wr_idx == CW'(NIBBLES - 1));
  assign nb_idx       = (idx == IW'(NIBBLES - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_capture || (wr_idx == CW'(NIBBLES))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // S-box inputs are pure muxes of one share each; zero whenever nothing is issued.
  always_comb begin
    busy      = (state == FEED) || (state == DRAIN);
    done      = (state == DONE);
    rnd_ready = issue;
    sbox_in1  = '0;
    sbox_in2  = '0;
    sbox_in3  = '0;
    sbox_nb   = '0;
    sbox_r    = '0;
    if (issue) begin
      sbox_in1 = st1[{idx, 2'b00} +: 4];
      sbox_in2 = st2[{idx, 2'b00} +: 4];
      sbox_in3 = st3[{idx, 2'b00} +: 4];
      sbox_nb  = {st3[{nb_idx, 2'b00} +: 4], st2[{nb_idx, 2'b00} +: 4]};
      sbox_r   = rnd_in;
    end
  end

  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = issue;
    for (int i = 1; i < SBOX_LAT; i++) vld_nxt[i] = vld[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st1        <= '0;
      st2        <= '0;
      st3        <= '0;
      idx        <= '0;
      wr_idx     <= '0;
      vld        <= '0;
      out_share1 <= '0;
      out_share2 <= '0;
      out_share3 <= '0;
    end else begin
      vld <= vld_nxt;
      if ((state == IDLE) && start) begin
        st1        <= in_share1;
        st2        <= in_share2;
        st3        <= in_share3;
        idx        <= '0;
        wr_idx     <= '0;
        out_share1 <= '0;
        out_share2 <= '0;
        out_share3 <= '0;
      end
      if (issue) idx <= last_issue ? '0 : idx + IW'(1);
      if (capture) begin
        out_share1[{wr_idx[IW-1:0], 2'b00} +: 4] <= sbox_out1;
        out_share2[{wr_idx[IW-1:0], 2'b00} +: 4] <= sbox_out2;
        out_share3[{wr_idx[IW-1:0], 2'b00} +: 4] <= sbox_out3;
        wr_idx <= wr_idx + CW'(1);
      end
    end
  end

endmodule
